nac_mem_read_arbiter: RTL and testbench

- Shares one AXI-style read master (AR + R channels) among NUM_PORTS stream prefetchers. Each prefetcher issues one-cycle request pulses.
- Latches each port's pending burst request and selects among pending ports round-robin. Issues exactly one burst at a time, returns a one-cycle grant pulse when the address is accepted, and routes the returning data beats back to the owning port.
- Sits between the NAC stream prefetchers and the DRAM/AXI read interconnect.

---
 rtl/nac_mem_read_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_nac_mem_read_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nac_mem_read_arbiter.sv
// Round-robin arbiter sharing one AXI-style read master (AR + R) among
// NUM_PORTS stream prefetchers. One burst in flight at a time; returning
// beats are routed to the port that owns the burst.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_pulse/addr/len  per-port one-cycle burst request (len is N-1 encoded)
//   port_flush          per-port abort; drops pending request and in-flight data
//   req_grant           one-cycle pulse when the port's AR is accepted
//   rsp_valid/rsp_data  one-hot beat strobe and shared beat data
//   m_ar*/m_r*          downstream read master
//   err_len             sticky: burst beat count disagreed with arlen+1
//   err_overrun         sticky: request while the port was pending or active
module nac_mem_read_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_pulse,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*8-1:0]      req_len,
    input  logic [NUM_PORTS-1:0]        port_flush,
    output logic [NUM_PORTS-1:0]        req_grant,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ADDR_W-1:0]           m_araddr,
    output logic [7:0]                  m_arlen,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    input  logic [DATA_W-1:0]           m_rdata,
    input  logic                        m_rvalid,
    input  logic                        m_rlast,
    output logic                        m_rready,
    output logic                        err_len,
    output logic                        err_overrun
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned CNT_W = LEN_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]           state, state_nxt;
    logic [PTR_W-1:0]     owner, owner_nxt;
    logic [PTR_W-1:0]     rr, rr_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 flush_drop, flush_drop_nxt;
    logic [NUM_PORTS-1:0] pending, pending_nxt, new_req;
    logic [ADDR_W-1:0]    pend_addr [NUM_PORTS];
    logic [LEN_W-1:0]     pend_len  [NUM_PORTS];

    logic [NUM_PORTS-1:0] grant_nxt, rsp_valid_nxt;
    logic [DATA_W-1:0]    rsp_data_nxt;
    logic [ADDR_W-1:0]    araddr_nxt;
    logic [LEN_W-1:0]     arlen_nxt;
    logic                 arvalid_nxt, rready_nxt, err_len_nxt, err_overrun_nxt;

    logic                 sel_found;
    logic [PTR_W-1:0]     sel_idx;
    logic                 drop_now;

    // Round-robin pick: first eligible port scanning upward from rr+1 with wrap.
    always_comb begin
        logic [PTR_W-1:0] idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = PTR_W'((32'(rr) + k) % NUM_PORTS);
            if (!sel_found && pending[idx] && !port_flush[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    // Per-port pending latch; flush beats a simultaneous pulse.
    always_comb begin
        logic busy;
        pending_nxt     = pending;
        err_overrun_nxt = err_overrun;
        busy            = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            busy = pending[i] || ((state != ST_IDLE) && (owner == PTR_W'(i)));
            if ((state == ST_ADDR) && m_arready && (owner == PTR_W'(i))) begin
                pending_nxt[i] = 1'b0;
            end
            if (port_flush[i]) begin
                pending_nxt[i] = 1'b0;
            end else if (req_pulse[i]) begin
                if (busy) begin
                    err_overrun_nxt = 1'b1;
                end else begin
                    pending_nxt[i] = 1'b1;
                end
            end
        end
    end

    assign new_req  = pending_nxt & ~pending;
    assign drop_now = flush_drop || port_flush[owner];

    // Burst FSM next-state and next registered outputs.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        rr_nxt         = rr;
        cnt_nxt        = cnt;
        flush_drop_nxt = flush_drop;
        grant_nxt      = '0;
        rsp_valid_nxt  = '0;
        rsp_data_nxt   = rsp_data;
        araddr_nxt     = m_araddr;
        arlen_nxt      = m_arlen;
        arvalid_nxt    = m_arvalid;
        rready_nxt     = m_rready;
        err_len_nxt    = err_len;

        case (state)
            ST_IDLE: begin
                if (sel_found) begin
                    owner_nxt      = sel_idx;
                    araddr_nxt     = pend_addr[sel_idx];
                    arlen_nxt      = pend_len[sel_idx];
                    arvalid_nxt    = 1'b1;
                    flush_drop_nxt = 1'b0;
                    state_nxt      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // AR stays asserted even if the owner is flushed meanwhile.
                if (port_flush[owner]) flush_drop_nxt = 1'b1;
                if (m_arready) begin
                    arvalid_nxt = 1'b0;
                    if (!drop_now) grant_nxt[owner] = 1'b1;
                    cnt_nxt     = '0;
                    rready_nxt  = 1'b1;
                    state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (port_flush[owner]) flush_drop_nxt = 1'b1;
                if (m_rvalid) begin
                    if (!drop_now) begin
                        rsp_valid_nxt[owner] = 1'b1;
                        rsp_data_nxt         = m_rdata;
                    end
                    if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
                    if (m_rlast) begin
                        if (cnt != {1'b0, m_arlen}) err_len_nxt = 1'b1;
                        rr_nxt         = owner;
                        flush_drop_nxt = 1'b0;
                        rready_nxt     = 1'b0;
                        state_nxt      = ST_IDLE;
                    end else if (cnt > {1'b0, m_arlen}) begin
                        err_len_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                arvalid_nxt = 1'b0;
                rready_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner       <= '0;
            rr          <= '0;
            cnt         <= '0;
            flush_drop  <= 1'b0;
            pending     <= '0;
            req_grant   <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            m_araddr    <= '0;
            m_arlen     <= '0;
            m_arvalid   <= 1'b0;
            m_rready    <= 1'b0;
            err_len     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            rr          <= rr_nxt;
            cnt         <= cnt_nxt;
            flush_drop  <= flush_drop_nxt;
            pending     <= pending_nxt;
            req_grant   <= grant_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_data    <= rsp_data_nxt;
            m_araddr    <= araddr_nxt;
            m_arlen     <= arlen_nxt;
            m_arvalid   <= arvalid_nxt;
            m_rready    <= rready_nxt;
            err_len     <= err_len_nxt;
            err_overrun <= err_overrun_nxt;
        end
    end

    // Request payload capture on a newly accepted pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                pend_addr[i] <= '0;
                pend_len[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (new_req[i]) begin
                    pend_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
                    pend_len[i]  <= req_len[i*LEN_W +: LEN_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_nac_mem_read_arbiter.sv
// Scoreboard bench for nac_mem_read_arbiter: expected ARs are queued when
// requests are driven, expected beats are queued when the slave model sends
// them, and a negedge monitor pops and compares against DUT outputs.
module tb_nac_mem_read_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    req_pulse;
    logic [NP*AW-1:0] req_addr;
    logic [NP*8-1:0]  req_len;
    logic [NP-1:0]    port_flush;
    logic [NP-1:0]    req_grant;
    logic [NP-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic [AW-1:0]    m_araddr;
    logic [7:0]       m_arlen;
    logic             m_arvalid;
    logic             m_arready;
    logic [DW-1:0]    m_rdata;
    logic             m_rvalid;
    logic             m_rlast;
    logic             m_rready;
    logic             err_len;
    logic             err_overrun;

    nac_mem_read_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_pulse(req_pulse), .req_addr(req_addr), .req_len(req_len),
        .port_flush(port_flush), .req_grant(req_grant),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .m_rlast(m_rlast), .m_rready(m_rready),
        .err_len(err_len), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int port; logic [31:0] addr; logic [7:0] len; bit grant; } ar_t;
    typedef struct { int port; logic [31:0] data; } rsp_t;

    ar_t  exp_ar[$];
    int   exp_grant[$];
    rsp_t exp_rsp[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cur_owner  = -1;
    int drop_port  = -1;
    int short_port = -1;
    int short_beat = 0;
    int ar_delay   = 0;
    int drop_beats = 0;
    int rsp_cnt[NP];
    int grant_cnt[NP];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic exp_ar_add(input int port, input logic [31:0] addr, input logic [7:0] len, input bit grant);
        ar_t e;
        e.port = port; e.addr = addr; e.len = len; e.grant = grant;
        exp_ar.push_back(e);
    endtask

    // Pulse every port in mask for one cycle; port i gets base + i*0x100.
    task automatic pulse(input logic [NP-1:0] mask, input logic [31:0] base, input logic [7:0] len);
        @(posedge clk); #1;
        for (int i = 0; i < int'(NP); i++) begin
            if (mask[i]) begin
                req_addr[i*AW +: AW] = base + 32'(i) * 32'h100;
                req_len[i*8 +: 8]    = len;
            end
        end
        req_pulse = mask;
        @(posedge clk); #1;
        req_pulse = '0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < int'(NP); i++) begin
            rsp_cnt[i]   = 0;
            grant_cnt[i] = 0;
        end
        drop_beats = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (n < 2000 && !(exp_ar.size() == 0 && exp_grant.size() == 0 &&
               exp_rsp.size() == 0 && !m_arvalid && !m_rready && !m_rvalid)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, 64'(n < 2000), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rready(input string tag);
        int n = 0;
        while (n < 200 && !m_rready) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rready_timeout"}, 64'(m_rready), 64'd1);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_ar.delete(); exp_grant.delete(); exp_rsp.delete();
        cur_owner = -1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Slave model: arready after ar_delay cycles, then back-to-back beats.
    initial begin : slave
        int sl_st, wait_cnt, idx, nb;
        logic [31:0] a;
        logic [31:0] d;
        sl_st = 0; wait_cnt = 0; idx = 0; nb = 0; a = '0; d = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
        forever begin
            @(posedge clk); #1;
            m_arready = 1'b0;
            if (!rst_n) begin
                m_rvalid = 1'b0; m_rlast = 1'b0; sl_st = 0; wait_cnt = 0;
            end else if (sl_st == 0) begin
                m_rvalid = 1'b0; m_rlast = 1'b0;
                if (m_arvalid) begin
                    if (wait_cnt >= ar_delay) begin
                        m_arready = 1'b1;
                        a = m_araddr;
                        nb = int'(m_arlen) + 1;
                        idx = 0; wait_cnt = 0; sl_st = 1;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else if (m_rready) begin
                if (idx == 0 && cur_owner == short_port) nb = short_beat + 1;
                d = {a[15:0], 16'(idx)} ^ 32'h5A5A_0000;
                m_rvalid = 1'b1;
                m_rdata  = d;
                m_rlast  = (idx == nb - 1);
                if (cur_owner == drop_port) drop_beats++;
                else exp_rsp.push_back('{cur_owner, d});
                idx++;
                if (idx == nb) sl_st = 0;
            end else begin
                m_rvalid = 1'b0; m_rlast = 1'b0;
            end
        end
    end

    // Monitor: AR handshakes, AR stability, grants and routed beats.
    initial begin : monitor
        bit          ar_wait;
        logic [40:0] ar_hold_val;
        ar_t         e;
        rsp_t        r;
        int          p;
        ar_wait = 0; ar_hold_val = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ar_wait = 0;
            end else begin
                if (ar_wait) check("ar_hold", 64'({m_arvalid, m_arlen, m_araddr}), 64'(ar_hold_val));
                ar_wait     = m_arvalid && !m_arready;
                ar_hold_val = {m_arvalid, m_arlen, m_araddr};

                if (req_grant != '0) begin
                    if (exp_grant.size() == 0) check("grant_unexpected", 64'(req_grant), 64'd0);
                    else begin
                        p = exp_grant.pop_front();
                        check("grant_port", 64'(req_grant), 64'(1 << p));
                    end
                    for (int i = 0; i < int'(NP); i++) if (req_grant[i]) grant_cnt[i]++;
                end

                if (rsp_valid != '0) begin
                    check("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
                    if (exp_rsp.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                    else begin
                        r = exp_rsp.pop_front();
                        check("rsp_port", 64'(rsp_valid), 64'(1 << r.port));
                        check("rsp_data", 64'(rsp_data), 64'(r.data));
                    end
                    for (int i = 0; i < int'(NP); i++) if (rsp_valid[i]) rsp_cnt[i]++;
                end

                if (m_arvalid && m_arready) begin
                    if (exp_ar.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
                    else begin
                        e = exp_ar.pop_front();
                        check("ar_addr", 64'(m_araddr), 64'(e.addr));
                        check("ar_len", 64'(m_arlen), 64'(e.len));
                        cur_owner = e.port;
                        if (e.grant) exp_grant.push_back(e.port);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        req_pulse = '0; req_addr = '0; req_len = '0; port_flush = '0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 64'({req_grant, rsp_valid, m_arlen, m_arvalid, m_rready, err_len, err_overrun}), 64'd0);
        check("rst_data", {rsp_data, m_araddr}, 64'd0);
        rst_n = 1'b1;

        // Single port 0, arready after 3 cycles, 16 beats.
        ar_delay = 3;
        exp_ar_add(0, 32'h1000, 8'd15, 1);
        pulse(4'b0001, 32'h1000, 8'd15);
        check("t1_arvalid_early", 64'(m_arvalid), 64'd0);
        @(posedge clk); #1;
        check("t1_arvalid_latency", 64'(m_arvalid), 64'd1);
        wait_idle("t1");
        check("t1_beats", 64'(rsp_cnt[0]), 64'd16);
        check("t1_grants", 64'(grant_cnt[0]), 64'd1);
        check("t1_errs", 64'({err_len, err_overrun}), 64'd0);

        // Port 3 burst leaves rr=3, so a full round then runs 0,1,2,3.
        ar_delay = 0;
        exp_ar_add(3, 32'h1300, 8'd3, 1);
        pulse(4'b1000, 32'h1000, 8'd3);
        wait_idle("t1b");
        clear_counts();
        for (int i = 0; i < 4; i++) exp_ar_add(i, 32'h2000 + 32'(i) * 32'h100, 8'd3, 1);
        pulse(4'b1111, 32'h2000, 8'd3);
        wait_idle("t2");
        for (int i = 0; i < 4; i++) check("t2_beats", 64'(rsp_cnt[i]), 64'd4);

        // rr=2 after port 2; ports 3 and 1 then follow in that order.
        clear_counts();
        exp_ar_add(2, 32'h3200, 8'd3, 1);
        pulse(4'b0100, 32'h3000, 8'd3);
        wait_rready("t2b");
        exp_ar_add(3, 32'h4300, 8'd3, 1);
        exp_ar_add(1, 32'h4100, 8'd3, 1);
        pulse(4'b1010, 32'h4000, 8'd3);
        wait_idle("t2b");
        check("t2b_beats1", 64'(rsp_cnt[1]), 64'd4);
        check("t2b_beats3", 64'(rsp_cnt[3]), 64'd4);

        // Flush port 2 while its AR waits 5 cycles for arready.
        clear_counts();
        ar_delay = 5;
        drop_port = 2;
        exp_ar_add(2, 32'h5200, 8'd7, 0);
        pulse(4'b0100, 32'h5000, 8'd7);
        n = 0;
        while (n < 50 && !m_arvalid) begin @(negedge clk); n++; end
        check("t3_arvalid", 64'(m_arvalid), 64'd1);
        @(posedge clk); #1 port_flush = 4'b0100;
        @(posedge clk); #1 port_flush = '0;
        wait_idle("t3");
        check("t3_dropped_beats", 64'(drop_beats), 64'd8);
        check("t3_no_grant", 64'(grant_cnt[2]), 64'd0);
        check("t3_no_rsp", 64'(rsp_cnt[2]), 64'd0);
        drop_port = -1;

        // Port 1 re-requests during its own DATA phase.
        clear_counts();
        ar_delay = 0;
        exp_ar_add(1, 32'h6100, 8'd7, 1);
        pulse(4'b0010, 32'h6000, 8'd7);
        wait_rready("t4");
        pulse(4'b0010, 32'h7000, 8'd7);
        wait_idle("t4");
        repeat (5) @(negedge clk);
        check("t4_overrun", 64'(err_overrun), 64'd1);
        check("t4_no_second_ar", 64'(m_arvalid), 64'd0);
        check("t4_len_ok", 64'(err_len), 64'd0);
        check("t4_beats", 64'(rsp_cnt[1]), 64'd8);

        // Early rlast on beat 3 of len=7, then queued port 3 is served.
        apply_reset();
        clear_counts();
        short_port = 0;
        short_beat = 2;
        exp_ar_add(0, 32'h8000, 8'd7, 1);
        pulse(4'b0001, 32'h8000, 8'd7);
        wait_rready("t5");
        exp_ar_add(3, 32'h9300, 8'd1, 1);
        pulse(4'b1000, 32'h9000, 8'd1);
        wait_idle("t5");
        check("t5_err_len", 64'(err_len), 64'd1);
        check("t5_overrun", 64'(err_overrun), 64'd0);
        check("t5_beats0", 64'(rsp_cnt[0]), 64'd3);
        check("t5_beats3", 64'(rsp_cnt[3]), 64'd2);
        short_port = -1;

        // Asynchronous reset in the middle of a DATA phase.
        apply_reset();
        clear_counts();
        exp_ar_add(1, 32'hA100, 8'd15, 1);
        pulse(4'b0010, 32'hA000, 8'd15);
        n = 0;
        while (n < 100 && rsp_valid == '0) begin @(negedge clk); n++; end
        check("t6_in_data", 64'(rsp_valid), 64'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", 64'({req_grant, rsp_valid, m_arlen, m_arvalid, m_rready, err_len, err_overrun}), 64'd0);
        check("t6_rst_data", {rsp_data, m_araddr}, 64'd0);
        exp_ar.delete(); exp_grant.delete(); exp_rsp.delete();
        cur_owner = -1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_counts();
        exp_ar_add(2, 32'hB200, 8'd3, 1);
        pulse(4'b0100, 32'hB000, 8'd3);
        wait_idle("t6");
        check("t6_beats", 64'(rsp_cnt[2]), 64'd4);
        check("t6_grant", 64'(grant_cnt[2]), 64'd1);
        check("t6_errs", 64'({err_len, err_overrun}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
